hub75_fb_rowloader: RTL and testbench

//  Converts a raster pixel stream (valid/ready, SOF/EOL-marked) into row-store

---
 rtl/hub75_fb_rowloader_pkg.sv | 26 ++
 rtl/hub75_fb_rowloader.sv | 184 ++++++++++++++++++
 tb/tb_hub75_fb_rowloader.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/hub75_fb_rowloader_pkg.sv
// -----------------------------------------------------------------------------
// hub75_fb_rowloader_pkg
//   Shared definitions for the HUB75 frame-buffer row loader:
//   - state_e      : row-loader sequencing states (FILL / WAIT / COMMIT)
//   - DEF_*        : default panel geometry and pixel width
//   - frame_lines(): number of lines in one frame (banks * rows per bank)
// -----------------------------------------------------------------------------
package hub75_fb_rowloader_pkg;

  typedef enum logic [1:0] {
    ST_FILL   = 2'd0,  // accepting pixels of the current line
    ST_WAIT   = 2'd1,  // line complete, waiting for the write-in stage
    ST_COMMIT = 2'd2   // swap+store pulse is on the outputs
  } state_e;

  localparam int DEF_N_BANKS  = 2;
  localparam int DEF_N_ROWS   = 32;
  localparam int DEF_N_COLS   = 64;
  localparam int DEF_BITDEPTH = 24;

  // Lines per frame; the line index wraps after this many commits.
  function automatic int frame_lines(input int n_banks, input int n_rows);
    return n_banks * n_rows;
  endfunction

endpackage

// File: rtl/hub75_fb_rowloader.sv
// -----------------------------------------------------------------------------
// hub75_fb_rowloader
//   Turns a raster pixel stream (valid/ready, SOF/EOL framing) into line-buffer
//   writes plus a swap+store commit per line for the frame-buffer write-in
//   stage. The stream is stalled while a finished line waits to be committed.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   in_data/in_sof/in_eol/in_valid/in_ready
//                     pixel stream; a beat is taken when in_valid & in_ready
//   wr_data/wr_col_addr/wr_en
//                     line-buffer write port, registered (1 cycle after beat)
//   wr_row_swap/wr_row_store/wr_bank_addr/wr_row_addr
//                     1-cycle commit pulses with the bank/row of the line
//   wr_row_rdy        write-in stage idle, a store may be issued
//   frame_done        1-cycle pulse with the commit of the last frame line
//   overflow          sticky: some line carried more than N_COLS pixels
// -----------------------------------------------------------------------------
module hub75_fb_rowloader
  import hub75_fb_rowloader_pkg::*;
#(
  parameter int N_BANKS     = DEF_N_BANKS,
  parameter int N_ROWS      = DEF_N_ROWS,
  parameter int N_COLS      = DEF_N_COLS,
  parameter int BITDEPTH    = DEF_BITDEPTH,
  parameter int LOG_N_BANKS = $clog2(N_BANKS),
  parameter int LOG_N_ROWS  = $clog2(N_ROWS),
  parameter int LOG_N_COLS  = $clog2(N_COLS)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [BITDEPTH-1:0]    in_data,
  input  logic                   in_sof,
  input  logic                   in_eol,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [LOG_N_BANKS-1:0] wr_bank_addr,
  output logic [LOG_N_ROWS-1:0]  wr_row_addr,
  output logic                   wr_row_store,
  input  logic                   wr_row_rdy,
  output logic                   wr_row_swap,
  output logic [BITDEPTH-1:0]    wr_data,
  output logic [LOG_N_COLS-1:0]  wr_col_addr,
  output logic                   wr_en,
  output logic                   frame_done,
  output logic                   overflow
);

  localparam int Y_W     = LOG_N_BANKS + LOG_N_ROWS;
  localparam int N_LINES = frame_lines(N_BANKS, N_ROWS);
  localparam logic [Y_W-1:0]      Y_LAST  = Y_W'(N_LINES - 1);
  // Column counter carries one extra bit so it can rest at N_COLS (saturated).
  localparam logic [LOG_N_COLS:0] COL_END = (LOG_N_COLS + 1)'(N_COLS);

  state_e                 state_q, state_d;
  logic [LOG_N_COLS:0]    col_q, col_d;
  logic [Y_W-1:0]         y_q, y_d;
  logic                   guard_q, guard_d;
  logic                   wr_en_q, wr_en_d;
  logic [BITDEPTH-1:0]    wr_data_q, wr_data_d;
  logic [LOG_N_COLS-1:0]  wr_col_q, wr_col_d;
  logic                   commit_q, commit_d;
  logic [LOG_N_BANKS-1:0] bank_q, bank_d;
  logic [LOG_N_ROWS-1:0]  row_q, row_d;
  logic                   frame_done_q, frame_done_d;
  logic                   overflow_q, overflow_d;

  // Effective column / line index of an accepted beat (SOF restarts both).
  logic [LOG_N_COLS:0]    col_eff;
  logic [Y_W-1:0]         y_eff;
  logic                   acc;

  assign in_ready = (state_q == ST_FILL);
  assign acc      = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    y_d          = y_q;
    wr_en_d      = 1'b0;
    wr_data_d    = wr_data_q;
    wr_col_d     = wr_col_q;
    commit_d     = 1'b0;
    bank_d       = bank_q;
    row_d        = row_q;
    frame_done_d = 1'b0;
    overflow_d   = overflow_q;
    // The write-in stage updates its ready flag one cycle after a store,
    // so its rdy is not trusted in the cycle right after our pulse.
    guard_d      = commit_q;
    col_eff      = in_sof ? '0 : col_q;
    y_eff        = in_sof ? '0 : y_q;

    unique case (state_q)
      ST_FILL: begin
        if (acc) begin
          // A SOF discards any partial line: only the index is reset, nothing
          // is committed for the abandoned row.
          y_d = y_eff;
          if (col_eff < COL_END) begin
            wr_en_d   = 1'b1;
            wr_data_d = in_data;
            wr_col_d  = col_eff[LOG_N_COLS-1:0];
            col_d     = col_eff + 1'b1;
          end else begin
            // Line longer than the buffer: drop the pixel, flag it forever.
            overflow_d = 1'b1;
            col_d      = col_eff;
          end
          if (in_eol) begin
            state_d = ST_WAIT;
            col_d   = '0;
          end
        end
      end

      ST_WAIT: begin
        if (!guard_q && wr_row_rdy) begin
          // Pulses are registered on entry so they line up with COMMIT;
          // the line index advances at the same time.
          state_d  = ST_COMMIT;
          commit_d = 1'b1;
          bank_d   = y_q[Y_W-1 -: LOG_N_BANKS];
          row_d    = y_q[LOG_N_ROWS-1:0];
          if (y_q == Y_LAST) begin
            frame_done_d = 1'b1;
            y_d          = '0;
          end else begin
            y_d = y_q + 1'b1;
          end
        end
      end

      ST_COMMIT: begin
        state_d = ST_FILL;
      end

      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_FILL;
      col_q        <= '0;
      y_q          <= '0;
      guard_q      <= 1'b0;
      wr_en_q      <= 1'b0;
      wr_data_q    <= '0;
      wr_col_q     <= '0;
      commit_q     <= 1'b0;
      bank_q       <= '0;
      row_q        <= '0;
      frame_done_q <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      y_q          <= y_d;
      guard_q      <= guard_d;
      wr_en_q      <= wr_en_d;
      wr_data_q    <= wr_data_d;
      wr_col_q     <= wr_col_d;
      commit_q     <= commit_d;
      bank_q       <= bank_d;
      row_q        <= row_d;
      frame_done_q <= frame_done_d;
      overflow_q   <= overflow_d;
    end
  end

  assign wr_en        = wr_en_q;
  assign wr_data      = wr_data_q;
  assign wr_col_addr  = wr_col_q;
  assign wr_row_swap  = commit_q;
  assign wr_row_store = commit_q;
  assign wr_bank_addr = bank_q;
  assign wr_row_addr  = row_q;
  assign frame_done   = frame_done_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_hub75_fb_rowloader.sv
// -----------------------------------------------------------------------------
// tb_hub75_fb_rowloader
//   Randomized stimulus against a line/frame level reference model: every
//   accepted beat yields an expected line-buffer write (or a drop once the
//   line is full), every accepted EOL yields an expected commit at the next
//   line index of the frame. A monitor matches the DUT's writes and commits
//   against those queues; directed checks cover latency, stalls, SOF, overflow
//   and reset.
// -----------------------------------------------------------------------------
module tb_hub75_fb_rowloader;

  localparam int NB = 2;
  localparam int NR = 32;
  localparam int NC = 64;
  localparam int BD = 24;

  logic          clk;
  logic          rst_n;
  logic [BD-1:0] in_data;
  logic          in_sof, in_eol, in_valid, in_ready;
  logic [0:0]    wr_bank_addr;
  logic [4:0]    wr_row_addr;
  logic          wr_row_store, wr_row_rdy, wr_row_swap;
  logic [BD-1:0] wr_data;
  logic [5:0]    wr_col_addr;
  logic          wr_en, frame_done, overflow;

  hub75_fb_rowloader #(
    .N_BANKS(NB), .N_ROWS(NR), .N_COLS(NC), .BITDEPTH(BD)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .in_data(in_data), .in_sof(in_sof), .in_eol(in_eol),
    .in_valid(in_valid), .in_ready(in_ready),
    .wr_bank_addr(wr_bank_addr), .wr_row_addr(wr_row_addr),
    .wr_row_store(wr_row_store), .wr_row_rdy(wr_row_rdy),
    .wr_row_swap(wr_row_swap), .wr_data(wr_data),
    .wr_col_addr(wr_col_addr), .wr_en(wr_en),
    .frame_done(frame_done), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_val(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
  endtask

  // ---------------- reference model ----------------
  typedef struct { int col; logic [BD-1:0] data; } wr_t;
  typedef struct { int bank; int row; bit fd; } cm_t;
  wr_t exp_wr[$];
  cm_t exp_cm[$];
  int  m_col = 0;
  int  m_y   = 0;
  bit  m_ovf = 0;

  task automatic model_accept(input logic [BD-1:0] d, input bit sof, input bit eol);
    wr_t w;
    cm_t c;
    if (sof) begin
      m_col = 0;
      m_y   = 0;
    end
    if (m_col < NC) begin
      w.col = m_col; w.data = d;
      exp_wr.push_back(w);
      m_col++;
    end else begin
      m_ovf = 1;
    end
    if (eol) begin
      c.bank = m_y / NR; c.row = m_y % NR; c.fd = (m_y == NB * NR - 1);
      exp_cm.push_back(c);
      m_y   = (m_y + 1) % (NB * NR);
      m_col = 0;
    end
  endtask

  // ---------------- monitor ----------------
  int fd_count = 0, st_count = 0, wr_count = 0;
  int last_bank = -1, last_row = -1;

  always @(negedge clk) begin
    wr_t e;
    cm_t c;
    if (rst_n) begin
      if (wr_en) begin
        wr_count++;
        if (exp_wr.size() == 0) check_val("unexp_wr", 1, 0);
        else begin
          e = exp_wr.pop_front();
          check_val("wr_col", longint'(wr_col_addr), e.col);
          check_val("wr_data", longint'(wr_data), longint'(e.data));
        end
      end
      if (wr_row_store || wr_row_swap || frame_done) begin
        check_val("swap_eq_store", longint'(wr_row_swap), longint'(wr_row_store));
        if (wr_row_store) st_count++;
        if (frame_done) fd_count++;
        last_bank = int'(wr_bank_addr);
        last_row  = int'(wr_row_addr);
        if (exp_cm.size() == 0) check_val("unexp_store", 1, 0);
        else begin
          c = exp_cm.pop_front();
          check_val("st_bank", longint'(wr_bank_addr), c.bank);
          check_val("st_row", longint'(wr_row_addr), c.row);
          check_val("st_frame_done", longint'(frame_done), c.fd);
        end
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic send_beat(input logic [BD-1:0] d, input bit sof, input bit eol);
    int w = 0;
    bit ok = 0;
    in_data = d; in_sof = sof; in_eol = eol; in_valid = 1'b1;
    while (!ok && w < 500) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk);
        #1;
        ok = 1;
      end
      w++;
    end
    if (!ok) check_val("accept_timeout", 0, 1);
    else model_accept(d, sof, eol);
    in_valid = 1'b0; in_sof = 1'b0; in_eol = 1'b0;
  endtask

  task automatic send_line(input int n, input bit sof, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_beat(BD'($urandom), sof && (i == 0), i == n - 1);
    end
  endtask

  task automatic wait_drain(input string tag);
    int w = 0;
    while ((exp_wr.size() + exp_cm.size()) != 0 && w < 300) begin
      @(negedge clk);
      w++;
    end
    #1;
    check_val(tag, exp_wr.size() + exp_cm.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int hi, st, fd0, st0, wr0;
    rst_n = 1'b0; wr_row_rdy = 1'b1;
    in_data = '0; in_sof = 1'b0; in_eol = 1'b0; in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_in_ready", longint'(in_ready), 1);
    check_val("rst_wr_en", longint'(wr_en), 0);
    check_val("rst_store", longint'(wr_row_store), 0);
    check_val("rst_swap", longint'(wr_row_swap), 0);
    check_val("rst_frame_done", longint'(frame_done), 0);
    check_val("rst_overflow", longint'(overflow), 0);
    check_val("rst_addr", longint'({wr_bank_addr, wr_row_addr, wr_col_addr}), 0);
    check_val("rst_data", longint'(wr_data), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // 1: full 64-pixel line, commit 2 cycles after the EOL beat
    for (int i = 0; i < NC; i++) send_beat(BD'($urandom), i == 0, i == NC - 1);
    check_val("t1_ready_wait", longint'(in_ready), 0);
    check_val("t1_no_early_store", longint'(wr_row_store), 0);
    @(posedge clk);
    #1;
    check_val("t1_store", longint'(wr_row_store), 1);
    check_val("t1_bank_row", longint'({wr_bank_addr, wr_row_addr}), 0);
    @(posedge clk);
    #1;
    check_val("t1_ready_back", longint'(in_ready), 1);
    check_val("t1_store_1cyc", longint'(wr_row_store), 0);
    wait_drain("t1_drain");

    // 2: full frame of random-length lines, then one extra line
    fd0 = fd_count;
    for (int l = 0; l < NB * NR; l++) send_line($urandom_range(1, 6), l == 0, 1'b1);
    wait_drain("t2_frame_drain");
    check_val("t2_frame_done_once", fd_count - fd0, 1);
    send_line(3, 1'b0, 1'b1);
    wait_drain("t2_line65_drain");
    check_val("t2_line65_addr", last_bank * NR + last_row, 0);

    // 3: write-in busy for 20 cycles after EOL
    wr_row_rdy = 1'b0;
    send_line(4, 1'b0, 1'b0);
    hi = 0; st = 0;
    repeat (20) begin
      @(negedge clk);
      hi += int'(in_ready);
      st += int'(wr_row_store);
    end
    check_val("t3_ready_low", hi, 0);
    check_val("t3_no_store", st, 0);
    @(posedge clk);
    #1;
    wr_row_rdy = 1'b1;
    @(posedge clk);
    #1;
    check_val("t3_store_after_rdy", longint'(wr_row_store), 1);
    check_val("t3_ready_in_commit", longint'(in_ready), 0);
    @(posedge clk);
    #1;
    check_val("t3_resume", longint'(in_ready), 1);
    wait_drain("t3_drain");

    // 4: SOF in the middle of a line
    st0 = st_count;
    for (int i = 0; i < 10; i++) send_beat(BD'($urandom), 1'b0, 1'b0);
    send_line(6, 1'b1, 1'b1);
    wait_drain("t4_drain");
    check_val("t4_one_store", st_count - st0, 1);
    check_val("t4_addr", last_bank * NR + last_row, 0);

    // 5: over-long line, then a short one
    wr0 = wr_count;
    send_line(70, 1'b0, 1'b0);
    wait_drain("t5_long_drain");
    check_val("t5_writes", wr_count - wr0, NC);
    check_val("t5_overflow", longint'(overflow), longint'(m_ovf));
    send_line(5, 1'b0, 1'b1);
    wait_drain("t5_short_drain");
    check_val("t5_overflow_sticky", longint'(overflow), 1);

    // 6: reset while a line waits for the write-in stage
    wr_row_rdy = 1'b0;
    send_line(3, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    exp_wr.delete(); exp_cm.delete();
    m_col = 0; m_y = 0; m_ovf = 0;
    #1;
    check_val("t6_ready", longint'(in_ready), 1);
    check_val("t6_overflow", longint'(overflow), 0);
    check_val("t6_pulses", longint'({wr_en, wr_row_store, wr_row_swap, frame_done}), 0);
    check_val("t6_addr", longint'({wr_bank_addr, wr_row_addr}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wr_row_rdy = 1'b1;
    st0 = st_count;
    repeat (5) @(posedge clk);
    #1;
    check_val("t6_no_store", st_count - st0, 0);
    send_line(4, 1'b0, 1'b1);
    wait_drain("t6_drain");
    check_val("t6_addr_y0", last_bank * NR + last_row, 0);
    check_val("final_overflow", longint'(overflow), longint'(m_ovf));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
